shift_frame_ctrl: RTL and testbench

Sequencer for the parallel-load shift register datapath. Accepts a byte over a valid/ready handshake and drives the register's parallel input and load strobe. It then issues exactly WIDTH shift enables and frames the register's serial output onto a line with a defined idle level. With the option enabled, it appends an even-parity bit. It sits between a byte producer and the shift register that carries the serial stream.

---
 rtl/shift_frame_pkg.sv | 16 +
 rtl/shift_frame_ctrl.sv | 117 +++++++++++
 tb/tb_shift_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_frame_pkg.sv
// Shared types and defaults for the shift-register frame sequencer.
// Optional even-parity bit is enabled by defining SHIFT_FRAME_PARITY_EN.
package shift_frame_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    PAR   = 3'd3,
    DONE  = 3'd4
  } frame_state_t;

  localparam int   DEF_WIDTH      = 8;
  localparam logic DEF_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer: accepts a word, loads the external shift register, issues WIDTH shifts
// and frames its serial output. Define SHIFT_FRAME_PARITY_EN to append an even-parity bit.
module shift_frame_ctrl
  import shift_frame_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic             cc,
  input  logic             rr,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic [WIDTH-1:0] PI,
  output logic             ll,
  output logic             sh_en,
  input  logic             sr_sout,
  output logic             line_o,
  output logic             busy,
  output logic             done
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  frame_state_t     state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic tx_ready_s, ll_s, sh_en_s, busy_s, done_s, line_s;

  // State, latched word and bit counter registers
  always_ff @(posedge cc) begin
    if (rr) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    tx_ready_s = 1'b0;
    ll_s       = 1'b0;
    sh_en_s    = 1'b0;
    busy_s     = 1'b1;
    done_s     = 1'b0;
    line_s     = IDLE_LEVEL;
    case (state_q)
      IDLE: begin
        busy_s     = 1'b0;
        tx_ready_s = 1'b1;
        if (tx_valid) begin
          data_d  = tx_data;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        ll_s    = 1'b1;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_en_s = 1'b1;
        line_s  = sr_sout;
        // Counter holds at LAST so it can never wrap inside a frame
        if (cnt_q < LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (cnt_q == LAST) begin
`ifdef SHIFT_FRAME_PARITY_EN
          state_d = PAR;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
`ifdef SHIFT_FRAME_PARITY_EN
      PAR: begin
        line_s  = ^data_q;
        state_d = DONE;
      end
`endif
      DONE: begin
        done_s  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Reset forces every control output to its quiet level even mid-frame
  assign tx_ready = tx_ready_s & ~rr;
  assign ll       = ll_s & ~rr;
  assign sh_en    = sh_en_s & ~rr;
  assign busy     = busy_s & ~rr;
  assign done     = done_s & ~rr;
  assign line_o   = rr ? IDLE_LEVEL : line_s;
  assign PI       = data_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Self-checking bench for shift_frame_ctrl with a behavioural shift register and a
// cycle-offset reference model; parity checks are built when SHIFT_FRAME_PARITY_EN is set.
module tb_shift_frame_ctrl;

  localparam int   W        = 8;
  localparam logic IDLE_LVL = 1'b1;
`ifdef SHIFT_FRAME_PARITY_EN
  localparam int   PEN      = 1;
`else
  localparam int   PEN      = 0;
`endif
  localparam int   FEND     = W + 2 + PEN;

  logic         cc = 1'b0;
  logic         rr = 1'b1;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_ready, ll, sh_en, sr_sout, line_o, busy, done;
  logic [W-1:0] PI;

  logic [W-1:0] sr_q  = '0;
  int           mt    = -1;
  logic [W-1:0] mbyte = '0;
  logic [W-1:0] mpi   = '0;
  int           cyc   = 0;
  int           acc_cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;

  shift_frame_ctrl #(.WIDTH(W), .IDLE_LEVEL(IDLE_LVL)) dut (
    .cc(cc), .rr(rr), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .PI(PI), .ll(ll), .sh_en(sh_en), .sr_sout(sr_sout), .line_o(line_o),
    .busy(busy), .done(done)
  );

  always #5 cc = ~cc;

  // External shift register, MSB first
  always @(posedge cc) begin
    if (rr) sr_q <= '0;
    else if (ll) sr_q <= PI;
    else if (sh_en) sr_q <= {sr_q[W-2:0], 1'b0};
  end
  assign sr_sout = sr_q[W-1];

  // Reference model: mt = cycles since accept (1 = load cycle), -1 when idle
  always @(posedge cc) begin
    cyc <= cyc + 1;
    if (rr) begin
      mt  <= -1;
      mpi <= '0;
    end else if (mt < 0) begin
      if (tx_valid) begin
        mt      <= 1;
        mbyte   <= tx_data;
        mpi     <= tx_data;
        acc_cyc <= cyc + 1;
      end
    end else if (mt == FEND) begin
      mt <= -1;
    end else begin
      mt <= mt + 1;
    end
  end

  // Expected {tx_ready, ll, sh_en, busy, done, line_o}
  function automatic logic [5:0] model_outs();
    if (rr) return {5'b00000, IDLE_LVL};
    if (mt < 0) return {5'b10000, IDLE_LVL};
    if (mt == 1) return {5'b01010, IDLE_LVL};
    if (mt >= 2 && mt <= W + 1) return {5'b00110, mbyte[W + 1 - mt]};
    if (PEN == 1 && mt == W + 2) return {5'b00010, ^mbyte};
    return {5'b00011, IDLE_LVL};
  endfunction

  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    @(posedge cc);
    #1;
    rr = r; tx_valid = v; tx_data = d;
    @(negedge cc);
  endtask

  task automatic drain();
    for (int i = 0; i < FEND + 2; i++) step(1'b0, 1'b0, W'($urandom));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, W'($urandom));
      n_cmp++;
      if ({tx_ready, ll, sh_en, busy, done, line_o} !== {5'b00000, IDLE_LVL}) begin
        n_bad++; $display("FAIL reset_outs cyc=%0d got=%b exp=%b", cyc,
          {tx_ready, ll, sh_en, busy, done, line_o}, {5'b00000, IDLE_LVL});
      end
      n_cmp++;
      if (PI !== '0) begin n_bad++; $display("FAIL reset_pi got=%h exp=0", PI); end
    end
    step(1'b0, 1'b1, 8'h5A);
    n_cmp++;
    if ({tx_ready, busy} !== 2'b10) begin
      n_bad++; $display("FAIL reset_release got ready/busy=%b exp=10", {tx_ready, busy});
    end
    step(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if ({ll, PI} !== {1'b1, 8'h5A}) begin
      n_bad++; $display("FAIL reset_first_accept got ll/PI=%b/%h exp=1/5a", ll, PI);
    end
    drain();
  endtask

  task automatic test_single_frame(input logic [W-1:0] b, input string tag);
    int sh_cnt = 0, ll_rel = -1, done_rel = -1, par_rel = -1;
    logic par_bit = 1'b0;
    logic [W-1:0] got = '0;
    step(1'b0, 1'b1, b);
    for (int k = 0; k < FEND + 1; k++) begin
      step(1'b0, 1'b0, W'($urandom));
      n_cmp++;
      if ({tx_ready, ll, sh_en, busy, done, line_o} !== model_outs()) begin
        n_bad++; $display("FAIL %s_cycle cyc=%0d got=%b exp=%b", tag, cyc,
          {tx_ready, ll, sh_en, busy, done, line_o}, model_outs());
      end
      if (sh_en) begin sh_cnt++; got = {got[W-2:0], line_o}; end
      if (ll && ll_rel < 0) ll_rel = cyc - (acc_cyc - 1);
      if (done && done_rel < 0) done_rel = cyc - (acc_cyc - 1);
      if (busy && !sh_en && !ll && !done && par_rel < 0) begin
        par_rel = cyc - (acc_cyc - 1); par_bit = line_o;
      end
    end
    n_cmp++;
    if (sh_cnt != W) begin n_bad++; $display("FAIL %s_shift_count got=%0d exp=%0d", tag, sh_cnt, W); end
    n_cmp++;
    if (ll_rel != 1) begin n_bad++; $display("FAIL %s_load_time got=N+%0d exp=N+1", tag, ll_rel); end
    n_cmp++;
    if (done_rel != W + 2 + PEN) begin
      n_bad++; $display("FAIL %s_done_time got=N+%0d exp=N+%0d", tag, done_rel, W + 2 + PEN);
    end
    n_cmp++;
    if (got !== b) begin n_bad++; $display("FAIL %s_line_bits got=%h exp=%h", tag, got, b); end
    if (PEN == 1) begin
      n_cmp++;
      if (par_rel != W + 2 || par_bit !== ^b) begin
        n_bad++; $display("FAIL %s_parity got=N+%0d/%b exp=N+%0d/%b", tag, par_rel, par_bit, W + 2, ^b);
      end
    end
    drain();
  endtask

`ifdef SHIFT_FRAME_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] bytes [2];
    logic         pexp  [2];
    bytes[0] = 8'h07; pexp[0] = 1'b1;
    bytes[1] = 8'h03; pexp[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      step(1'b0, 1'b1, bytes[j]);
      for (int k = 0; k < FEND + 1; k++) begin
        step(1'b0, 1'b0, 8'h00);
        if (cyc - (acc_cyc - 1) == W + 2) begin
          n_cmp++;
          if ({sh_en, busy, done, line_o} !== {3'b010, pexp[j]}) begin
            n_bad++; $display("FAIL parity_bit byte=%h got=%b exp=%b", bytes[j],
              {sh_en, busy, done, line_o}, {3'b010, pexp[j]});
          end
        end
        if (cyc - (acc_cyc - 1) == W + 3) begin
          n_cmp++;
          if (done !== 1'b1) begin n_bad++; $display("FAIL parity_done byte=%h got=%b exp=1", bytes[j], done); end
        end
      end
      drain();
    end
  endtask
`endif

  task automatic test_back_to_back();
    int ll_seen = 0, t1 = -1, t2 = -1;
    step(1'b0, 1'b1, 8'h01);
    for (int k = 0; k < FEND + 5; k++) begin
      step(1'b0, 1'b1, 8'hFF);
      if (ll) begin
        ll_seen++;
        if (ll_seen == 1) t1 = cyc;
        if (ll_seen == 2) t2 = cyc;
      end
      if (ll_seen == 1) begin
        n_cmp++;
        if (PI !== 8'h01) begin n_bad++; $display("FAIL b2b_pi_hold cyc=%0d got=%h exp=01", cyc, PI); end
      end
      if (ll && ll_seen == 2) begin
        n_cmp++;
        if (PI !== 8'hFF) begin n_bad++; $display("FAIL b2b_pi_second got=%h exp=ff", PI); end
      end
    end
    n_cmp++;
    if (t2 - t1 != W + 3 + PEN || t1 < 0 || t2 < 0) begin
      n_bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", t2 - t1, W + 3 + PEN);
    end
    step(1'b0, 1'b0, 8'h00);
    drain();
    drain();
  endtask

  task automatic test_reset_mid();
    int dcount = 0;
    step(1'b0, 1'b1, W'($urandom));
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    n_cmp++;
    if ({sh_en, done, busy} !== 3'b000) begin
      n_bad++; $display("FAIL midrst_during got sh_en/done/busy=%b exp=000", {sh_en, done, busy});
    end
    step(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if ({tx_ready, sh_en, busy, PI} !== {3'b100, 8'h00}) begin
      n_bad++; $display("FAIL midrst_after got=%b/%h exp=100/00", {tx_ready, sh_en, busy}, PI);
    end
    for (int k = 0; k < FEND; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if (done) dcount++;
    end
    n_cmp++;
    if (dcount != 0) begin n_bad++; $display("FAIL midrst_no_done got=%0d exp=0", dcount); end
    test_single_frame(8'h3C, "midrst_fresh");
  endtask

  task automatic test_ignore_inputs();
    logic [W-1:0] b = W'($urandom);
    logic [W-1:0] got = '0;
    step(1'b0, 1'b1, b);
    for (int k = 1; k <= W + 1; k++) begin
      step(1'b0, 1'($urandom), W'($urandom));
      n_cmp++;
      if ({tx_ready, PI} !== {1'b0, b}) begin
        n_bad++; $display("FAIL ignore_inputs cyc=%0d got=%b/%h exp=0/%h", cyc, tx_ready, PI, b);
      end
      if (sh_en) got = {got[W-2:0], line_o};
    end
    n_cmp++;
    if (got !== b) begin n_bad++; $display("FAIL ignore_line got=%h exp=%h", got, b); end
    step(1'b0, 1'b0, 8'h00);
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) != 0), W'($urandom));
      n_cmp++;
      if ({tx_ready, ll, sh_en, busy, done, line_o} !== model_outs()) begin
        n_bad++; $display("FAIL random_outs cyc=%0d got=%b exp=%b", cyc,
          {tx_ready, ll, sh_en, busy, done, line_o}, model_outs());
      end
      n_cmp++;
      if (PI !== mpi) begin n_bad++; $display("FAIL random_pi cyc=%0d got=%h exp=%h", cyc, PI, mpi); end
    end
    step(1'b0, 1'b0, 8'h00);
    drain();
  endtask

  initial begin
    test_reset();
    test_single_frame(8'hA5, "single_a5");
`ifdef SHIFT_FRAME_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid();
    test_ignore_inputs();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
